// File: rtl/face_det_pkg.sv
// Shared types and constants for the face-detection sweep control path.
package face_det_pkg;

    localparam int unsigned SCALE_W    = 5;
    localparam int unsigned MAX_SCALES = 1 << SCALE_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCALE    = 3'd1,
        CLASSIFY = 3'd2,
        NEXT     = 3'd3,
        DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/scale_sweep_ctrl.sv
// Frame sweep sequencer: waits for a loaded frame, runs every scale round and feeds windows to the classifier.
// Optional macro EARLY_EXIT_EN: first detected face ends the frame immediately.
module scale_sweep_ctrl
    import face_det_pkg::*;
#(
    parameter int unsigned NUM_SCALES = 12,
    parameter int unsigned CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ram_full,
    input  logic               scaler_end,
    input  logic               win_full,
    input  logic               clf_done,
    input  logic               clf_face,
    output logic               scaler_en,
    output logic [SCALE_W-1:0] round_scale,
    output logic               clf_start,
    output logic               face_found,
    output logic               face_status,
    output logic [CNT_W-1:0]   face_count,
    output logic               frame_done,
    output logic               busy
);

    localparam logic [SCALE_W-1:0] LAST_SCALE = SCALE_W'(NUM_SCALES - 1);

    state_e             state_q;
    logic [SCALE_W-1:0] round_q;
    logic               end_q, armed_q;
    logic               scaler_en_q, clf_start_q, face_found_q;
    logic               face_status_q, frame_done_q, busy_q;
    logic               start_frame, face_hit;

    assign start_frame = (state_q == IDLE) && armed_q && ram_full;
    assign face_hit    = (state_q == CLASSIFY) && clf_done && clf_face;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            round_q       <= '0;
            end_q         <= 1'b0;
            armed_q       <= 1'b1;
            scaler_en_q   <= 1'b0;
            clf_start_q   <= 1'b0;
            face_found_q  <= 1'b0;
            face_status_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            clf_start_q  <= 1'b0;
            face_found_q <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!ram_full) armed_q <= 1'b1;
                    if (start_frame) begin
                        round_q       <= '0;
                        face_status_q <= 1'b0;
                        scaler_en_q   <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= SCALE;
                    end
                end
                SCALE: begin
                    if (win_full) begin
                        // Coincident end is remembered so the window is classified first.
                        end_q       <= scaler_end;
                        scaler_en_q <= 1'b0;
                        clf_start_q <= 1'b1;
                        state_q     <= CLASSIFY;
                    end else if (scaler_end) begin
                        scaler_en_q <= 1'b0;
                        state_q     <= NEXT;
                    end
                end
                CLASSIFY: begin
                    if (scaler_end) end_q <= 1'b1;
                    if (clf_done) begin
                        face_found_q <= clf_face;
                        if (clf_face) face_status_q <= 1'b1;
                        if (end_q || scaler_end) begin
                            state_q <= NEXT;
                        end else begin
                            scaler_en_q <= 1'b1;
                            state_q     <= SCALE;
                        end
`ifdef EARLY_EXIT_EN
                        // Later assignments override the normal continuation above.
                        if (clf_face) begin
                            end_q        <= 1'b0;
                            scaler_en_q  <= 1'b0;
                            frame_done_q <= 1'b1;
                            state_q      <= DONE;
                        end
`endif
                    end
                end
                NEXT: begin
                    end_q <= 1'b0;
                    if (round_q == LAST_SCALE) begin
                        frame_done_q <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        round_q     <= round_q + SCALE_W'(1);
                        scaler_en_q <= 1'b1;
                        state_q     <= SCALE;
                    end
                end
                DONE: begin
                    armed_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    scaler_en_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_face_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (start_frame),
        .inc_i (face_hit),
        .cnt_o (face_count)
    );

    assign scaler_en   = scaler_en_q;
    assign round_scale = round_q;
    assign clf_start   = clf_start_q;
    assign face_found  = face_found_q;
    assign face_status = face_status_q;
    assign frame_done  = frame_done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_scale_sweep_ctrl.sv
// Scoreboard bench for scale_sweep_ctrl (3 scales, 2-bit face counter); honours EARLY_EXIT_EN.
module tb_scale_sweep_ctrl;

    localparam int unsigned NS   = 3;
    localparam int unsigned CW   = 2;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, ram_full, scaler_end, win_full, clf_done, clf_face;
    logic          scaler_en, clf_start, face_found, face_status, frame_done, busy;
    logic [4:0]    round_scale;
    logic [CW-1:0] face_count;

    always #5 clk = ~clk;

    scale_sweep_ctrl #(.NUM_SCALES(NS), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .ram_full    (ram_full),
        .scaler_end  (scaler_end),
        .win_full    (win_full),
        .clf_done    (clf_done),
        .clf_face    (clf_face),
        .scaler_en   (scaler_en),
        .round_scale (round_scale),
        .clf_start   (clf_start),
        .face_found  (face_found),
        .face_status (face_status),
        .face_count  (face_count),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    typedef enum int {EV_START, EV_FACE, EV_DONE} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        int unsigned val;
        logic        st;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cur_round = 0;
    int unsigned model_cnt = 0;
    logic        model_st  = 1'b0;

    // Output monitor: every observed pulse must match the head of the expectation queue.
    always @(negedge clk) begin : mon
        ev_t obs[$];
        ev_t e;
        obs.delete();
        if (rst === 1'b1) begin
            if (clf_start === 1'b1)
                obs.push_back('{kind: EV_START, val: int'(round_scale), st: 1'b0});
            if (face_found === 1'b1)
                obs.push_back('{kind: EV_FACE, val: 0, st: 1'b0});
            if (frame_done === 1'b1)
                obs.push_back('{kind: EV_DONE, val: int'(face_count), st: face_status});
            foreach (obs[i]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got kind=%0d val=%0d st=%b, required none",
                             obs[i].kind, obs[i].val, obs[i].st);
                end else begin
                    e = exp_q.pop_front();
                    if (obs[i].kind !== e.kind || obs[i].val !== e.val || obs[i].st !== e.st) begin
                        errors++;
                        $display("FAIL event_match: got kind=%0d val=%0d st=%b, required kind=%0d val=%0d st=%b",
                                 obs[i].kind, obs[i].val, obs[i].st, e.kind, e.val, e.st);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_en();
        int n = 0;
        while (scaler_en !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (scaler_en !== 1'b1) begin
            errors++;
            $display("FAIL wait_en_timeout: scaler_en=%b required 1", scaler_en);
        end
        checks++;
        if (round_scale !== 5'(cur_round)) begin
            errors++;
            $display("FAIL round_scale: got %0d required %0d", round_scale, cur_round);
        end
    endtask

    task automatic push_done();
        exp_q.push_back('{kind: EV_DONE, val: model_cnt, st: model_st});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle_timeout: busy=%b required 0", busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d outstanding required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic start_frame();
        ram_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 ram_full = 1'b1;
        cur_round = 0;
        model_cnt = 0;
        model_st  = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (scaler_en !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: scaler_en=%b busy=%b required 1 1", scaler_en, busy);
        end
        checks++;
        if (face_count !== '0 || face_status !== 1'b0 || round_scale !== 5'd0) begin
            errors++;
            $display("FAIL start_clear: count=%0d status=%b round=%0d required 0 0 0",
                     face_count, face_status, round_scale);
        end
    endtask

    task automatic end_scale();
        wait_en();
        if (cur_round == NS - 1) push_done();
        @(posedge clk);
        #1 scaler_end = 1'b1;
        @(posedge clk);
        #1 scaler_end = 1'b0;
        cur_round++;
    endtask

    task automatic do_window(input bit face, input bit end_same, input bit end_in_clf);
        bit early;
        bit ends;
        bit exp_en;
`ifdef EARLY_EXIT_EN
        early = face;
`else
        early = 1'b0;
`endif
        ends = (end_same || end_in_clf) && !early;
        wait_en();
        exp_q.push_back('{kind: EV_START, val: cur_round, st: 1'b0});
        @(posedge clk);
        #1 win_full = 1'b1;
        scaler_end = end_same;
        @(posedge clk);
        #1 win_full = 1'b0;
        scaler_end = 1'b0;
        checks++;
        if (scaler_en !== 1'b0) begin
            errors++;
            $display("FAIL classify_en: scaler_en=%b required 0", scaler_en);
        end
        if (end_in_clf) begin
            @(posedge clk);
            #1 scaler_end = 1'b1;
            @(posedge clk);
            #1 scaler_end = 1'b0;
        end
        @(posedge clk);
        #1 clf_done = 1'b1;
        clf_face = face;
        if (face) begin
            model_cnt = (model_cnt == CMAX) ? CMAX : model_cnt + 1;
            model_st  = 1'b1;
            exp_q.push_back('{kind: EV_FACE, val: 0, st: 1'b0});
        end
        if (early || (ends && cur_round == NS - 1)) push_done();
        @(posedge clk);
        #1 clf_done = 1'b0;
        clf_face = 1'b0;
        exp_en = !ends && !early;
        checks++;
        if (scaler_en !== exp_en) begin
            errors++;
            $display("FAIL done_to_en: scaler_en=%b required %b", scaler_en, exp_en);
        end
        if (early) begin
            checks++;
            if (frame_done !== 1'b1 || round_scale !== 5'(cur_round)) begin
                errors++;
                $display("FAIL early_exit: frame_done=%b round=%0d required 1 %0d",
                         frame_done, round_scale, cur_round);
            end
        end
        if (ends) cur_round++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ram_full = 1'b0; scaler_end = 1'b0; win_full = 1'b0; clf_done = 1'b0; clf_face = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({scaler_en, round_scale, clf_start, face_found, face_status, face_count, frame_done, busy} !== '0) begin
            errors++;
            $display("FAIL reset_state: en=%b round=%0d start=%b ff=%b st=%b cnt=%0d fd=%b busy=%b required all 0",
                     scaler_en, round_scale, clf_start, face_found, face_status, face_count, frame_done, busy);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic_sweep();
        start_frame();
        for (int unsigned s = 0; s < NS; s++) begin
            do_window(1'b0, 1'b0, 1'b0);
            end_scale();
        end
        wait_idle();
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || scaler_en !== 1'b0) begin
            errors++;
            $display("FAIL no_rearm: busy=%b scaler_en=%b required 0 0", busy, scaler_en);
        end
    endtask

    task automatic test_faces();
        start_frame();
        do_window(1'b0, 1'b0, 1'b0);
        ram_full = 1'b0;
        wait_en();
        @(posedge clk);
        #1 clf_done = 1'b1;
        clf_face = 1'b1;
        @(posedge clk);
        #1 clf_done = 1'b0;
        clf_face = 1'b0;
        end_scale();
        do_window(1'b1, 1'b0, 1'b0);
        do_window(1'b1, 1'b0, 1'b0);
        do_window(1'b0, 1'b0, 1'b0);
        end_scale();
        do_window(1'b0, 1'b0, 1'b0);
        end_scale();
        wait_idle();
    endtask

    task automatic test_same_cycle_end();
        start_frame();
        do_window(1'b0, 1'b1, 1'b0);
        do_window(1'b0, 1'b0, 1'b1);
        do_window(1'b0, 1'b0, 1'b0);
        end_scale();
        wait_idle();
    endtask

    task automatic test_saturate();
        start_frame();
        for (int unsigned k = 0; k < 5; k++) do_window(1'b1, 1'b0, 1'b0);
        for (int unsigned s = 0; s < NS; s++) end_scale();
        wait_idle();
    endtask

    task automatic test_reset_mid();
        start_frame();
        end_scale();
        end_scale();
        wait_en();
        exp_q.push_back('{kind: EV_START, val: cur_round, st: 1'b0});
        @(posedge clk);
        #1 win_full = 1'b1;
        @(posedge clk);
        #1 win_full = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({scaler_en, round_scale, clf_start, face_found, face_status, face_count, frame_done, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid: en=%b round=%0d start=%b ff=%b st=%b cnt=%0d fd=%b busy=%b required all 0",
                     scaler_en, round_scale, clf_start, face_found, face_status, face_count, frame_done, busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_pending: got %0d outstanding required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        rst = 1'b1;
        cur_round = 0;
        model_cnt = 0;
        model_st  = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (scaler_en !== 1'b1 || round_scale !== 5'd0) begin
            errors++;
            $display("FAIL restart_after_reset: scaler_en=%b round=%0d required 1 0", scaler_en, round_scale);
        end
        for (int unsigned s = 0; s < NS; s++) end_scale();
        wait_idle();
    endtask

    task automatic test_early_exit();
        start_frame();
        do_window(1'b1, 1'b0, 1'b0);
`ifndef EARLY_EXIT_EN
        for (int unsigned s = 0; s < NS; s++) end_scale();
`endif
        wait_idle();
`ifdef EARLY_EXIT_EN
        checks++;
        if (round_scale !== 5'd0) begin
            errors++;
            $display("FAIL early_round: got %0d required 0", round_scale);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
`ifndef EARLY_EXIT_EN
        test_faces();
        test_saturate();
`endif
        test_same_cycle_end();
        test_reset_mid();
        test_early_exit();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
